// File: rtl/aes_round_sched.sv
// Iterative AES round sequencer: initial AddRoundKey, then one shared round
// datapath driven NR times with keys fetched from an external key table.
module aes_round_sched #(
  parameter int unsigned NR        = 10,
  parameter int unsigned ROUND_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   key_idx,
  input  logic [127:0] key_data,
  output logic [127:0] rnd_state,
  output logic [127:0] rnd_key,
  output logic         rnd_final,
  input  logic [127:0] rnd_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned DW = 128;
  localparam int unsigned RW = 4;
  localparam int unsigned LW = 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [RW-1:0] LAST_RND = RW'(NR);
  localparam logic [LW-1:0] LAST_LAT = LW'(ROUND_LAT);

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] st_q, st_d;
  logic [RW-1:0] rnd_q, rnd_d;
  logic [LW-1:0] lat_q, lat_d;

  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic [RW-1:0] key_idx_q, key_idx_d;
  logic          rnd_final_q, rnd_final_d;

  // Next-state logic; output flags are computed from the next state so they
  // come straight out of flops in the cycle the state is entered.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rnd_d   = rnd_q;
    lat_d   = lat_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          st_d    = in_data ^ key_data;
          rnd_d   = RW'(1);
          lat_d   = '0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (lat_q == LAST_LAT) begin
          st_d  = rnd_result;
          lat_d = '0;
          if (rnd_q == LAST_RND) begin
            state_d = S_DONE;
          end else begin
            rnd_d = rnd_q + RW'(1);
          end
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    key_idx_d   = (state_d == S_ROUND) ? rnd_d : '0;
    rnd_final_d = (state_d == S_ROUND) && (rnd_d == LAST_RND);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      st_q        <= '0;
      rnd_q       <= '0;
      lat_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      key_idx_q   <= '0;
      rnd_final_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      rnd_q       <= rnd_d;
      lat_q       <= lat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      key_idx_q   <= key_idx_d;
      rnd_final_q <= rnd_final_d;
    end
  end

  // The key table answers combinationally, so the round key is a pass-through.
  assign rnd_key   = key_data;
  assign rnd_state = st_q;
  assign out_data  = st_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign key_idx   = key_idx_q;
  assign rnd_final = rnd_final_q;

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: AES-128 key table and 2-edge round datapath
// models around the DUT, checked against a whole-block AES reference.
module tb_aes_round_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   key_idx;
  logic [127:0] key_data;
  logic [127:0] rnd_state;
  logic [127:0] rnd_key;
  logic         rnd_final;
  logic [127:0] rnd_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aes_round_sched #(.NR(10), .ROUND_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .key_idx(key_idx), .key_data(key_data),
    .rnd_state(rnd_state), .rnd_key(rnd_key), .rnd_final(rnd_final),
    .rnd_result(rnd_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  // ---------------- AES-128 arithmetic ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse (x^254) then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, p, rl, res;
    inv = 8'h01; p = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) inv = gmul(inv, p);
      p = gmul(p, p);
    end
    res = inv; rl = inv;
    for (int k = 0; k < 4; k++) begin
      rl  = {rl[6:0], rl[7]};
      res = res ^ rl;
    end
    return res ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(4*c)   -: 8];
      a1 = s[127-8*(4*c+1) -: 8];
      a2 = s[127-8*(4*c+2) -: 8];
      a3 = s[127-8*(4*c+3) -: 8];
      o[127-8*(4*c)   -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[127-8*(4*c+3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                            input logic fin);
    logic [127:0] t;
    t = sub_shift(s);
    if (!fin) t = mix(t);
    return t ^ k;
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] prev, input logic [7:0] rcon);
    logic [31:0] t, rw, w0, w1, w2, w3;
    rw = {prev[23:0], prev[31:24]};
    t  = {sbox(rw[31:24]), sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])} ^ {rcon, 24'h0};
    w0 = prev[127:96] ^ t;
    w1 = prev[95:64]  ^ w0;
    w2 = prev[63:32]  ^ w1;
    w3 = prev[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Whole-block reference encryption.
  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] s, k;
    logic [7:0]   rc;
    s = pt ^ key; k = key; rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      k  = next_rk(k, rc);
      rc = xtime(rc);
      s  = round_fn(s, k, r == 10);
    end
    return s;
  endfunction

  // ---------------- Environment models ----------------
  logic [127:0] rk [0:10];
  logic [127:0] r1, r2;

  task automatic load_key(input logic [127:0] key);
    logic [7:0] rc;
    rk[0] = key; rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      rk[r] = next_rk(rk[r-1], rc);
      rc    = xtime(rc);
    end
  endtask

  always_comb key_data = (key_idx <= 4'd10) ? rk[key_idx] : '0;

  // Shared round datapath with two-edge registered latency.
  always @(posedge clk) begin
    r1 <= round_fn(rnd_state, rnd_key, rnd_final);
    r2 <= r1;
  end
  assign rnd_result = r2;

  // ---------------- Checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One block: optional ignored in_valid pulse mid-ROUND, bp cycles of backpressure.
  task automatic do_block(input string tag, input logic [127:0] pt, input logic [127:0] exp_ct,
                          input int bp, input bit junk);
    int cyc, errs, fin, exp_k;
    @(negedge clk);
    check({tag, ".in_ready"}, 128'(in_ready), 128'd1);
    check({tag, ".idle_key_idx"}, 128'(key_idx), 128'd0);
    in_valid  = 1'b1;
    in_data   = pt;
    out_ready = (bp == 0);
    @(negedge clk);
    cyc = 1; errs = 0; fin = 0;
    while (!out_valid && cyc < 200) begin
      exp_k = (cyc - 1) / 3 + 1;
      if (32'(key_idx) != exp_k || rnd_final != (exp_k == 10) || !busy || in_ready) errs++;
      if (rnd_final) fin++;
      in_valid = junk && (cyc == 7);
      in_data  = junk ? ~pt : pt;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, ".latency"}, 128'(cyc), 128'd31);
    check({tag, ".key_seq"}, 128'(errs), 128'd0);
    check({tag, ".final_cycles"}, 128'(fin), 128'd3);
    check({tag, ".ct"}, out_data, exp_ct);
    check({tag, ".done_flags"}, 128'({key_idx, rnd_final, in_ready, busy}), 128'({4'd0, 1'b0, 1'b0, 1'b1}));
    if (bp > 0) begin
      errs = 0;
      repeat (bp) begin
        @(negedge clk);
        if (out_data !== exp_ct || !out_valid || in_ready) errs++;
      end
      check({tag, ".hold"}, 128'(errs), 128'd0);
      out_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, ".drain"}, 128'({out_valid, in_ready, busy}), 128'({1'b0, 1'b1, 1'b0}));
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs[3];

  initial begin
    logic [127:0] key, pt, c1key, c1pt, c1ct;
    logic [127:0] cts[2];
    int tout[2];
    int acc2, nout, cyc, errs;

    c1key = 128'h000102030405060708090a0b0c0d0e0f;
    c1pt  = 128'h00112233445566778899aabbccddeeff;
    c1ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    vecs[0] = '{key: c1key, pt: c1pt, ct: c1ct};
    vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                pt:  128'h3243f6a8885a308d313198a2e0370734,
                ct:  128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = '{key: 128'h0, pt: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    load_key(c1key);
    repeat (3) @(negedge clk);
    check("reset.flags", 128'({in_ready, out_valid, busy, rnd_final, key_idx}),
          128'({1'b1, 1'b0, 1'b0, 1'b0, 4'd0}));
    check("reset.out_data", out_data, 128'h0);
    check("reset.rnd_state", rnd_state, 128'h0);
    rst_n = 1'b1;

    // Known-answer vectors.
    for (int i = 0; i < 3; i++) begin
      load_key(vecs[i].key);
      do_block($sformatf("vec%0d", i), vecs[i].pt, vecs[i].ct, 0, 1'b0);
    end

    // Backpressure and ignored input while busy.
    load_key(c1key);
    do_block("backpressure", c1pt, c1ct, 20, 1'b0);
    do_block("ignored_in", c1pt, c1ct, 0, 1'b1);

    // Back-to-back with in_valid held high.
    pt = 128'hdeadbeef0123456789abcdeffedcba98;
    acc2 = -1; nout = 0; tout[0] = 0; tout[1] = 0; cts[0] = '0; cts[1] = '0;
    @(negedge clk);
    in_valid = 1'b1; in_data = c1pt; out_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (c > 0 && in_ready && in_valid && acc2 < 0) acc2 = c;
      if (out_valid && nout < 2) begin
        cts[nout] = out_data; tout[nout] = c; nout++;
      end
      @(negedge clk);
      if (c == 0) in_data = pt;
      if (acc2 >= 0) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b.accept2", 128'(acc2), 128'd32);
    check("b2b.count", 128'(nout), 128'd2);
    check("b2b.t1", 128'(tout[0]), 128'd31);
    check("b2b.t2", 128'(tout[1]), 128'd63);
    check("b2b.ct1", cts[0], c1ct);
    check("b2b.ct2", cts[1], aes_enc(c1key, pt));

    // Reset during round 5 aborts the block.
    @(negedge clk);
    in_valid = 1'b1; in_data = c1pt;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (key_idx != 4'd5 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst.reach_round5", 128'(key_idx), 128'd5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst.flags", 128'({busy, out_valid, in_ready, rnd_final, key_idx}),
          128'({1'b0, 1'b0, 1'b1, 1'b0, 4'd0}));
    check("midrst.st", rnd_state, 128'h0);
    errs = 0;
    repeat (35) begin
      @(negedge clk);
      if (out_valid || busy) errs++;
    end
    check("midrst.no_output", 128'(errs), 128'd0);
    do_block("after_rst", c1pt, c1ct, 0, 1'b0);

    // Randomized blocks against the reference.
    for (int i = 0; i < 6; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      load_key(key);
      do_block($sformatf("rand%0d", i), pt, aes_enc(key, pt),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
